// File: rtl/fifo_ctrl_if.sv
// User-side handshake bundle for fifo_ctrl: write/read requests, read data and error clear.
// The FIFO controller connects as slave; the producer/consumer logic connects as master.
interface fifo_ctrl_if #(
  parameter int DATA = 16
);
  logic            wr_en;
  logic [DATA-1:0] wr_data;
  logic            rd_en;
  logic [DATA-1:0] rd_data;
  logic            rd_valid;
  logic            clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM (port A write, port B read).
// Holds pointers, occupancy, registered full/empty/threshold flags and sticky error flags.
module fifo_ctrl #(
  parameter int DATA      = 16,
  parameter int ADDR      = 5,
  parameter int AFULL_TH  = 2**ADDR - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic            clK,
  input  logic            rst,
  fifo_ctrl_if.slave      bus,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [ADDR:0]   count,
  output logic            overflow,
  output logic            underflow,
  output logic            ram_a_WR,
  output logic [ADDR-1:0] ram_a_ADDR,
  output logic [DATA-1:0] ram_a_data_IN,
  output logic            ram_b_WR,
  output logic [ADDR-1:0] ram_b_ADDR,
  output logic [DATA-1:0] ram_b_data_IN,
  input  logic [DATA-1:0] ram_b_data_OUT
);

  localparam int            DEPTH    = 2**ADDR;
  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);
  localparam logic [ADDR:0] DEPTH_C  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AFULL_C  = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0] AEMPTY_C = (ADDR+1)'(AEMPTY_TH);

  logic [ADDR:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR:0] count_reg, count_next;
  logic          full_reg, empty_reg, afull_reg, aempty_reg;
  logic          rd_valid_reg;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wa, ra;

  // Acceptance looks only at registered flags, so no request reaches a flag combinationally.
  assign wa = bus.wr_en & ~full_reg;
  assign ra = bus.rd_en & ~empty_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wa) wr_ptr_next = wr_ptr_reg + ONE;
    if (ra) rd_ptr_next = rd_ptr_reg + ONE;
    if (wa && !ra)      count_next = count_reg + ONE;
    else if (ra && !wa) count_next = count_reg - ONE;
  end

  // Clear first, then set, so a set on the same edge overrides the clear.
  always_comb begin
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (bus.clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (bus.wr_en && full_reg)  overflow_next  = 1'b1;
    if (bus.rd_en && empty_reg) underflow_next = 1'b1;
  end

  always_ff @(posedge clK or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == DEPTH_C);
      empty_reg     <= (count_next == '0);
      afull_reg     <= (count_next >= AFULL_C);
      aempty_reg    <= (count_next <= AEMPTY_C);
      rd_valid_reg  <= ra;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // The RAM registers port B, so its output lines up with rd_valid without another stage here.
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = ram_b_data_OUT;

  assign ram_a_WR      = wa;
  assign ram_a_ADDR    = wr_ptr_reg[ADDR-1:0];
  assign ram_a_data_IN = bus.wr_data;
  assign ram_b_WR      = 1'b0;
  assign ram_b_ADDR    = rd_ptr_reg[ADDR-1:0];
  assign ram_b_data_IN = '0;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that owns a single dual-port RAM instance (DATA wide, 2**ADDR deep) and turns it into a first-in/first-out buffer. Port A is the write port and port B the read port. The block holds the read/write pointers, occupancy count, full/empty and threshold flags, and sticky error flags, and drives the RAM address, write-enable and data pins directly. Two instances of this block plus two RAMs form the team's standard clock-shared FIFO.

## Interface
Parameters:
- DATA, 16, word width in bits
- ADDR, 5, RAM address width; depth = 2**ADDR
- AFULL_TH, 2**ADDR-2, almost_full asserted when count >= AFULL_TH (legal range 1..2**ADDR)
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH (legal range 0..2**ADDR-1)

Ports (name, direction, width, meaning):
- clK, in, 1, sole clock; all state updates on its rising edge
- rst, in, 1, reset; asynchronous, active-high
- wr_en, in, 1, write request
- wr_data, in, DATA, write word
- rd_en, in, 1, read request
- rd_data, out, DATA, read word; valid only while rd_valid=1
- rd_valid, out, 1, rd_data holds the word from the read accepted on the previous edge
- full / empty, out, 1, count == 2**ADDR / count == 0
- almost_full / almost_empty, out, 1, threshold flags
- count, out, ADDR+1, current occupancy 0..2**ADDR
- overflow / underflow, out, 1, sticky: write refused while full / read refused while empty
- clr_err, in, 1, clears overflow and underflow
- ram_a_WR, out, 1; ram_a_ADDR, out, ADDR; ram_a_data_IN, out, DATA: RAM port A
- ram_b_WR, out, 1 (constant 0); ram_b_ADDR, out, ADDR; ram_b_data_IN, out, DATA (constant 0): RAM port B
- ram_b_data_OUT, in, DATA, registered RAM port B read data

## Operation
- wr_ptr and rd_ptr are ADDR+1 bits wide. RAM addresses use the low ADDR bits. Increments wrap modulo 2**(ADDR+1).
- Accepted write: wa = wr_en & ~full. Accepted read: ra = rd_en & ~empty. Both depend on the registered flags only.
- RAM drive is combinational: ram_a_WR = wa, ram_a_ADDR = wr_ptr[ADDR-1:0], ram_a_data_IN = wr_data, ram_b_ADDR = rd_ptr[ADDR-1:0].
- On each edge:
  - wr_ptr += wa
  - rd_ptr += ra
  - count += wa − ra
  - full, empty, almost_full and almost_empty are recomputed from the next count, so all flags stay consistent with count in every cycle.
- rd_valid <= ra. rd_data = ram_b_data_OUT, passed through combinationally.
- Simultaneous events:
  - When full, wr_en+rd_en gives read accepted, write refused, overflow set, count decrements by 1.
  - When empty, wr_en+rd_en gives write accepted, read refused, underflow set, count increments by 1.
  - Otherwise both are accepted and count is unchanged.
- Error flags: overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty. Otherwise clr_err clears them. If set and clear occur on the same edge, set wins.
- Refused requests change no pointer, count or RAM state.
- Same-address read/write hazard cannot occur: a word written at edge N is readable no earlier than edge N+1, because empty/count are registered.

## Timing
- Reset (asynchronous assert, values take effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, almost_empty=1, almost_full=0
  - rd_valid=0, overflow=0, underflow=0
- A read in flight when reset asserts is discarded; rd_valid stays 0.
- Reset deassertion is used as-is; the integrator synchronizes it externally.
- Read latency: rd_en accepted at edge N → rd_valid=1 and rd_data valid in the cycle after edge N. Back-to-back reads sustain one word per clock.
- Write latency: wr_en accepted at edge N → count/empty update at edge N; the word is readable by rd_en sampled at edge N+1.
- Throughput: one write and one read per clock, simultaneously.
- Flags are registered. There are no combinational paths from wr_en/rd_en to any flag.

## Test plan
- Reset then idle: after rst pulse → count=0, empty=1, almost_empty=1, full=0, rd_valid=0, ram_a_WR=0.
- Fill/drain (ADDR=5): write 0x0000..0x001F on 32 consecutive cycles → full=1, count=32, almost_full first at count=30. Then 32 reads → rd_data 0x0000..0x001F in order, one per cycle with rd_valid=1 starting one cycle after the first read; empty=1 at the end.
- Wrap-around: 20 writes, 20 reads, repeated 4 times with distinct data → data order preserved, pointers wrap past 31 and 63, no spurious full or empty.
- Simultaneous at boundaries: when full, wr_en=rd_en=1 → count 32→31, overflow=1, first word read. When empty, both asserted → count 0→1, underflow=1, rd_valid=0 next cycle.
- Sticky errors: rd_en while empty → underflow=1 and held; clr_err=1 in the same cycle as another rd_en on empty → underflow stays 1; clr_err alone → 0.
- Reset mid-operation: at count=10 with rd_en accepted, assert rst between edges → all outputs return to reset values immediately, rd_valid=0, and a subsequent write/read returns the new data.
